// File: rtl/atm_pkg.sv
// Shared constants and types for the ATM front end: key codes, default card/PIN
// provisioning and the PIN-entry state encoding.
package atm_pkg;

  localparam logic [3:0]  KEY_CLEAR         = 4'hC;
  localparam logic [3:0]  KEY_ENTER         = 4'hE;
  localparam logic [3:0]  DEFAULT_CARD_ID   = 4'b1010;
  localparam logic [15:0] DEFAULT_PIN_VALUE = 16'h0123;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_CHECK,
    S_GRANTED,
    S_LOCKED
  } atm_state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/atm_idle_timer.sv
// One-shot inactivity timer: a restart arms it, and once TIMEOUT_CYC cycles pass
// without another restart, expired is high for exactly the cycle before the flush edge.
module atm_idle_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam int            TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] LOAD      = TW'(TIMEOUT_CYC - 1);
  localparam logic          ONE_CYCLE = (TIMEOUT_CYC == 1);

  logic [TW-1:0] cnt;

  // Loading TIMEOUT_CYC-1 and flagging the 1->0 step makes the consumer act on
  // the TIMEOUT_CYC-th edge after the restart; a spent timer stays at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (restart) begin
      cnt     <= LOAD;
      expired <= ONE_CYCLE;
    end else if (enable && cnt != '0) begin
      cnt     <= cnt - TW'(1);
      expired <= (cnt == TW'(1));
    end else begin
      expired <= 1'b0;
    end
  end

endmodule

// File: rtl/atm_pin_entry.sv
// PIN-entry and authentication front end: card check, PIN shift buffer, fail
// counter with sticky lockout, and an inactivity flush of partial entries.
module atm_pin_entry
  import atm_pkg::*;
#(
  parameter int                      PIN_DIGITS  = 4,
  parameter int                      MAX_TRIES   = 3,
  parameter int                      TIMEOUT_CYC = 1000,
  parameter logic [3:0]              CARD_ID     = DEFAULT_CARD_ID,
  parameter logic [4*PIN_DIGITS-1:0] PIN_VALUE   = (4*PIN_DIGITS)'(DEFAULT_PIN_VALUE)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] card_swipe,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       auth_ok,
  output logic       auth_fail,
  output logic       locked,
  output logic       timeout,
  output logic [2:0] digits_entered,
  output logic       busy,
  output atm_state_e state_dbg
);

  localparam int            BUF_W = 4 * PIN_DIGITS;
  localparam int            FW    = $clog2(MAX_TRIES + 1);
  localparam logic [2:0]    PIN_N = 3'(PIN_DIGITS);
  localparam logic [FW-1:0] MAX_T = FW'(MAX_TRIES);

  atm_state_e        state;
  logic [BUF_W-1:0]  pin_buf;
  logic [FW-1:0]     fail_cnt;
  logic [FW-1:0]     fail_next;
  logic              card_present;
  logic              key_hit;
  logic              pin_match;
  logic              timer_restart;
  logic              timer_enable;
  logic              timer_expired;

  // key_valid is a one-cycle strobe with no back-pressure: a key is consumed on
  // the edge it is sampled, or dropped if the current state does not take keys.
  assign card_present = (card_swipe == CARD_ID);
  assign key_hit      = key_valid && (is_digit(key_code) || key_code == KEY_CLEAR ||
                                      key_code == KEY_ENTER);
  assign pin_match    = (pin_buf == PIN_VALUE) && (digits_entered == PIN_N);
  assign fail_next    = fail_cnt + FW'(1);
  assign state_dbg    = state;

  // Restart on every entry into COLLECT and on every recognised key there.
  assign timer_restart = card_present &&
                         ((state == S_IDLE) ||
                          (state == S_COLLECT && key_hit) ||
                          (state == S_CHECK && !pin_match && fail_next != MAX_T));
  assign timer_enable  = (state == S_COLLECT);

  atm_idle_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_idle_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (timer_restart),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      pin_buf        <= '0;
      digits_entered <= '0;
      fail_cnt       <= '0;
      auth_ok        <= 1'b0;
      auth_fail      <= 1'b0;
      locked         <= 1'b0;
      timeout        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      auth_fail <= 1'b0;
      timeout   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (card_present) begin
            state <= S_COLLECT;
            busy  <= 1'b1;
          end
        end
        S_COLLECT: begin
          if (!card_present) begin
            state          <= S_IDLE;
            pin_buf        <= '0;
            digits_entered <= '0;
            busy           <= 1'b0;
          end else if (key_hit) begin
            if (is_digit(key_code)) begin
              if (digits_entered < PIN_N) begin
                pin_buf        <= (pin_buf << 4) | BUF_W'(key_code);
                digits_entered <= digits_entered + 3'd1;
              end
            end else if (key_code == KEY_CLEAR) begin
              pin_buf        <= '0;
              digits_entered <= '0;
            end else begin
              state <= S_CHECK;
            end
          end else if (timer_expired) begin
            pin_buf        <= '0;
            digits_entered <= '0;
            timeout        <= 1'b1;
          end
        end
        S_CHECK: begin
          if (!card_present) begin
            state          <= S_IDLE;
            pin_buf        <= '0;
            digits_entered <= '0;
            busy           <= 1'b0;
          end else if (pin_match) begin
            state    <= S_GRANTED;
            fail_cnt <= '0;
            auth_ok  <= 1'b1;
            busy     <= 1'b0;
          end else begin
            auth_fail      <= 1'b1;
            fail_cnt       <= fail_next;
            pin_buf        <= '0;
            digits_entered <= '0;
            if (fail_next == MAX_T) begin
              state  <= S_LOCKED;
              locked <= 1'b1;
              busy   <= 1'b0;
            end else begin
              state <= S_COLLECT;
            end
          end
        end
        S_GRANTED: begin
          if (!card_present) begin
            state          <= S_IDLE;
            pin_buf        <= '0;
            digits_entered <= '0;
            auth_ok        <= 1'b0;
          end
        end
        S_LOCKED: begin
          locked <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atm_pin_entry.sv
// Directed bench for atm_pin_entry: entry, lockout, clear/overflow, card removal,
// inactivity timeout and reset-during-entry scenarios.
module tb_atm_pin_entry;
  import atm_pkg::*;

  localparam logic [3:0] CARD = 4'b1010;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] card_swipe = 4'h0;
  logic [3:0] key_code = 4'h0;
  logic       key_valid = 1'b0;
  logic       auth_ok, auth_fail, locked, timeout, busy;
  logic [2:0] digits_entered;
  atm_state_e state_dbg;

  int tests_run = 0;
  int tests_failed = 0;
  int fail_pulses = 0;
  int timeout_pulses = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  atm_pin_entry #(
    .TIMEOUT_CYC (20)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .card_swipe     (card_swipe),
    .key_code       (key_code),
    .key_valid      (key_valid),
    .auth_ok        (auth_ok),
    .auth_fail      (auth_fail),
    .locked         (locked),
    .timeout        (timeout),
    .digits_entered (digits_entered),
    .busy           (busy),
    .state_dbg      (state_dbg)
  );

  always @(negedge clk) begin
    if (auth_fail) fail_pulses <= fail_pulses + 1;
    if (timeout)   timeout_pulses <= timeout_pulses + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_code  = k;
    key_valid = 1'b1;
    tick(1);
    key_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset      = 1'b1;
    card_swipe = 4'h0;
    key_valid  = 1'b0;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic swipe();
    card_swipe = CARD;
    tick(1);
  endtask

  task automatic wrong_entry();
    press(4'd0); press(4'd0); press(4'd0); press(4'd0); press(KEY_ENTER);
  endtask

  task automatic good_entry();
    press(4'd0); press(4'd1); press(4'd2); press(4'd3); press(KEY_ENTER);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    tests_run++; if (auth_ok !== 1'b0) begin tests_failed++; $display("FAIL reset_auth_ok got %b expected 0", auth_ok); end
    tests_run++; if (auth_fail !== 1'b0) begin tests_failed++; $display("FAIL reset_auth_fail got %b expected 0", auth_fail); end
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL reset_locked got %b expected 0", locked); end
    tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout got %b expected 0", timeout); end
    tests_run++; if (digits_entered !== 3'd0) begin tests_failed++; $display("FAIL reset_digits got %0d expected 0", digits_entered); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b expected 0", busy); end
    tests_run++; if (state_dbg !== S_IDLE) begin tests_failed++; $display("FAIL reset_state got %0d expected %0d", state_dbg, S_IDLE); end
    reset = 1'b0;
  endtask

  task automatic test_valid_entry();
    int f0;
    apply_reset();
    f0 = fail_pulses;
    swipe();
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL valid_busy_after_card got %b expected 1", busy); end
    press(4'd0); press(4'd1); press(4'd2); press(4'd3);
    tests_run++; if (digits_entered !== 3'd4) begin tests_failed++; $display("FAIL valid_digits got %0d expected 4", digits_entered); end
    press(KEY_ENTER);
    tests_run++; if (auth_ok !== 1'b0) begin tests_failed++; $display("FAIL valid_auth_ok_in_check got %b expected 0", auth_ok); end
    tick(1);
    tests_run++; if (auth_ok !== 1'b1) begin tests_failed++; $display("FAIL valid_auth_ok got %b expected 1", auth_ok); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL valid_busy_granted got %b expected 0", busy); end
    tests_run++; if (digits_entered !== 3'd4) begin tests_failed++; $display("FAIL valid_digits_granted got %0d expected 4", digits_entered); end
    tick(1);
    tests_run++; if (fail_pulses - f0 !== 0) begin tests_failed++; $display("FAIL valid_no_auth_fail got %0d expected 0", fail_pulses - f0); end
  endtask

  task automatic test_lockout();
    int f0;
    apply_reset();
    exp_q = '{1'b0, 1'b0, 1'b1};
    swipe();
    f0 = fail_pulses;
    for (int i = 0; i < 3; i++) begin
      wrong_entry();
      tick(1);
      tests_run++; if (auth_fail !== 1'b1) begin tests_failed++; $display("FAIL lockout_fail_pulse_%0d got %b expected 1", i, auth_fail); end
      tests_run++; if (locked !== exp_q[0]) begin tests_failed++; $display("FAIL lockout_locked_%0d got %b expected %b", i, locked, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    good_entry();
    tick(2);
    tests_run++; if (auth_ok !== 1'b0) begin tests_failed++; $display("FAIL lockout_auth_ok got %b expected 0", auth_ok); end
    tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL lockout_sticky got %b expected 1", locked); end
    tests_run++; if (state_dbg !== S_LOCKED) begin tests_failed++; $display("FAIL lockout_state got %0d expected %0d", state_dbg, S_LOCKED); end
    tests_run++; if (fail_pulses - f0 !== 3) begin tests_failed++; $display("FAIL lockout_pulse_count got %0d expected 3", fail_pulses - f0); end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL lockout_reset_clears got %b expected 0", locked); end
  endtask

  task automatic test_clear_overflow();
    apply_reset();
    swipe();
    press(4'd9); press(4'd9);
    tests_run++; if (digits_entered !== 3'd2) begin tests_failed++; $display("FAIL clear_before got %0d expected 2", digits_entered); end
    press(KEY_CLEAR);
    tests_run++; if (digits_entered !== 3'd0) begin tests_failed++; $display("FAIL clear_after got %0d expected 0", digits_entered); end
    press(4'd0); press(4'd1); press(4'd2); press(4'd3); press(4'd7);
    tests_run++; if (digits_entered !== 3'd4) begin tests_failed++; $display("FAIL overflow_digits got %0d expected 4", digits_entered); end
    press(KEY_ENTER);
    tick(1);
    tests_run++; if (auth_ok !== 1'b1) begin tests_failed++; $display("FAIL overflow_auth_ok got %b expected 1", auth_ok); end
    card_swipe = 4'h0;
    tick(1);
    swipe();
    press(4'd0); press(4'd1); press(KEY_ENTER);
    tick(1);
    tests_run++; if (auth_fail !== 1'b1) begin tests_failed++; $display("FAIL short_pin_fail got %b expected 1", auth_fail); end
    wrong_entry();
    tick(1);
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL short_pin_count2 got %b expected 0", locked); end
    wrong_entry();
    tick(1);
    tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL short_pin_count3 got %b expected 1", locked); end
  endtask

  task automatic test_card_removal();
    apply_reset();
    swipe();
    good_entry();
    card_swipe = 4'h0;
    tick(1);
    tests_run++; if (auth_ok !== 1'b0) begin tests_failed++; $display("FAIL removal_in_check_ok got %b expected 0", auth_ok); end
    tests_run++; if (auth_fail !== 1'b0) begin tests_failed++; $display("FAIL removal_in_check_fail got %b expected 0", auth_fail); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL removal_in_check_busy got %b expected 0", busy); end
    swipe();
    good_entry();
    tick(1);
    tests_run++; if (auth_ok !== 1'b1) begin tests_failed++; $display("FAIL removal_granted got %b expected 1", auth_ok); end
    card_swipe = 4'h0;
    tick(1);
    tests_run++; if (auth_ok !== 1'b0) begin tests_failed++; $display("FAIL removal_drops_auth got %b expected 0", auth_ok); end
    tests_run++; if (digits_entered !== 3'd0) begin tests_failed++; $display("FAIL removal_digits got %0d expected 0", digits_entered); end
    swipe();
    wrong_entry(); tick(1);
    wrong_entry(); tick(1);
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL removal_two_fails got %b expected 0", locked); end
    card_swipe = 4'h0;
    tick(1);
    swipe();
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL removal_reswipe_busy got %b expected 1", busy); end
    wrong_entry(); tick(1);
    tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL removal_no_bypass got %b expected 1", locked); end
  endtask

  task automatic test_timeout();
    int t0, f0;
    apply_reset();
    swipe();
    t0 = timeout_pulses;
    f0 = fail_pulses;
    press(4'd0); press(4'd1);
    tick(19);
    tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL timeout_early got %b expected 0", timeout); end
    tests_run++; if (digits_entered !== 3'd2) begin tests_failed++; $display("FAIL timeout_digits_held got %0d expected 2", digits_entered); end
    tick(1);
    tests_run++; if (timeout !== 1'b1) begin tests_failed++; $display("FAIL timeout_pulse got %b expected 1", timeout); end
    tests_run++; if (digits_entered !== 3'd0) begin tests_failed++; $display("FAIL timeout_flush got %0d expected 0", digits_entered); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL timeout_stays_collect got %b expected 1", busy); end
    tick(1);
    tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL timeout_one_cycle got %b expected 0", timeout); end
    tick(25);
    tests_run++; if (timeout_pulses - t0 !== 1) begin tests_failed++; $display("FAIL timeout_once got %0d expected 1", timeout_pulses - t0); end
    tests_run++; if (fail_pulses - f0 !== 0) begin tests_failed++; $display("FAIL timeout_not_failure got %0d expected 0", fail_pulses - f0); end
    press(4'd0);
    tick(19);
    press(4'd5);
    tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL timeout_key_wins got %b expected 0", timeout); end
    tests_run++; if (digits_entered !== 3'd2) begin tests_failed++; $display("FAIL timeout_key_wins_digits got %0d expected 2", digits_entered); end
    tick(19);
    tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL timeout_restarted_early got %b expected 0", timeout); end
    tick(1);
    tests_run++; if (timeout !== 1'b1) begin tests_failed++; $display("FAIL timeout_restarted_pulse got %b expected 1", timeout); end
  endtask

  task automatic test_reset_mid_entry();
    apply_reset();
    swipe();
    press(4'd0); press(4'd1);
    reset = 1'b1;
    tick(1);
    tests_run++; if (digits_entered !== 3'd0) begin tests_failed++; $display("FAIL midreset_digits got %0d expected 0", digits_entered); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midreset_busy got %b expected 0", busy); end
    tests_run++; if (auth_ok !== 1'b0) begin tests_failed++; $display("FAIL midreset_auth_ok got %b expected 0", auth_ok); end
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL midreset_locked got %b expected 0", locked); end
    tests_run++; if (timeout !== 1'b0 || auth_fail !== 1'b0) begin tests_failed++; $display("FAIL midreset_pulses got %b%b expected 00", timeout, auth_fail); end
    reset = 1'b0;
    tick(1);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL midreset_recollect got %b expected 1", busy); end
    good_entry();
    tick(1);
    tests_run++; if (auth_ok !== 1'b1) begin tests_failed++; $display("FAIL midreset_auth got %b expected 1", auth_ok); end
  endtask

  initial begin
    test_reset();
    test_valid_entry();
    test_lockout();
    test_clear_overflow();
    test_card_removal();
    test_timeout();
    test_reset_mid_entry();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/atm_pin_entry.md
# atm_pin_entry

PIN-entry and authentication front end for `ATM_Machine`. It sits directly upstream of the ATM transaction logic. It accepts the card-reader code and debounced keypad strobes, assembles a multi-digit PIN, and compares it to the provisioned value. It counts failed attempts and produces the `auth_ok` / `locked` qualifiers that gate all downstream transactions. Once `auth_ok` is high, downstream logic consumes keys directly; this block ignores them.

## Interface
- `PIN_DIGITS`, default 4: digits per PIN, range 1–7.
- `MAX_TRIES`, default 3: failed checks before lockout, minimum 1.
- `TIMEOUT_CYC`, default 1000: key-inactivity cycles before the buffer is flushed.
- `CARD_ID`, default 4'b1010: accepted card code.
- `PIN_VALUE`, default 16'h0123: expected PIN, BCD, last digit in the LSB nibble, `4*PIN_DIGITS` bits used.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `card_swipe`  in  4  card-reader code, level; card present iff it equals `CARD_ID`.
- `key_code`  in  4  keypad code; valid only when `key_valid` = 1.
- `key_valid`  in  1  single-cycle key strobe.
- `auth_ok`  out  1  level; PIN accepted and card still present.
- `auth_fail`  out  1  one-cycle pulse per failed check.
- `locked`  out  1  level; lockout, sticky until `reset`.
- `timeout`  out  1  one-cycle pulse when the buffer is flushed for inactivity.
- `digits_entered`  out  3  digits currently buffered.
- `busy`  out  1  high in COLLECT or CHECK.

## Operation
- Key codes:
  - 0–9: digit.
  - 4'hC: clear.
  - 4'hE: enter.
  - All other codes are ignored, with no timer restart.
- States: IDLE, COLLECT, CHECK, GRANTED, LOCKED.
- IDLE: buffer and count are zero. Card present → COLLECT.
- COLLECT:
  - Digit with count < `PIN_DIGITS`: shift into the buffer, count+1.
  - Digit with a full buffer: dropped.
  - Clear: buffer and count → 0.
  - Enter → CHECK, whatever the count. A short PIN always mismatches.
- CHECK (one cycle): compare the buffer against `PIN_VALUE`, with count == `PIN_DIGITS` required.
  - Match → GRANTED; fail counter → 0.
  - Mismatch → `auth_fail` pulse, fail counter +1, buffer cleared.
    - If the new count == `MAX_TRIES` → LOCKED; otherwise → COLLECT.
- GRANTED: `auth_ok` = 1. All keys are ignored.
- LOCKED: `locked` = 1. Card, keys and timer are ignored; only `reset` exits.
- Card removal in COLLECT, CHECK or GRANTED → IDLE next cycle. It clears the buffer, count and `auth_ok`. The fail counter is preserved, so re-swiping cannot bypass lockout. In CHECK, card removal takes priority and no compare result is produced.
- Inactivity timer, active in COLLECT only:
  - Restarts on every accepted key and on entry to COLLECT.
  - After `TIMEOUT_CYC` cycles with no key, the buffer and count are cleared and `timeout` pulses; the state stays COLLECT.
  - The timeout is not a failed attempt.
  - A key arriving in the expiry cycle wins and the timeout is suppressed.
- Priority: `reset` > card removal > key > timeout.

## Timing
- All outputs are registered.
- Reset values:
  - `auth_ok` = 0, `auth_fail` = 0, `locked` = 0, `timeout` = 0.
  - `digits_entered` = 0, `busy` = 0.
  - State is IDLE; the fail counter and timer are 0.
- Card presented at edge N → `busy` = 1 after edge N+1.
- A key sampled at edge N updates `digits_entered` after edge N.
- Enter sampled at edge N → CHECK after N. After edge N+1, exactly one of the following is visible:
  - `auth_ok` = 1, or
  - `auth_fail` = 1 (with `locked` = 1 on the `MAX_TRIES`th failure).
- Keys arriving while in CHECK are dropped.
- Card removal at edge N → `auth_ok` = 0 after edge N+1.
- `reset` asserted mid-entry clears everything on that edge, including `locked`.

## Structure
- `atm_pkg` holds:
  - key-code constants `KEY_CLEAR` = 4'hC and `KEY_ENTER` = 4'hE;
  - the state enum;
  - the default `CARD_ID` and `PIN_VALUE` constants, which `ATM_Machine` also uses.
- One sub-module, `atm_idle_timer`: a loadable down-counter with `restart`, `enable` and a one-cycle `expired` output, of width `$clog2(TIMEOUT_CYC+1)`.
- The FSM, PIN shift buffer and fail counter live in the top module.

## Test plan
- **Valid entry:** card 4'b1010, keys 0,1,2,3,E → `auth_ok` = 1 two edges after E; `digits_entered` = 4; `auth_fail` never pulses.
- **Lockout:** three entries of 0,0,0,0,E (`MAX_TRIES` = 3) → `auth_fail` pulses three times; `locked` = 1 after the third; a correct PIN afterwards leaves `auth_ok` = 0 until `reset`.
- **Clear and overflow:** keys 9,9,C,0,1,2,3,7,E → the 7 is dropped, so `auth_ok` = 1. Short entry 0,1,E → `auth_fail` pulse; fail counter = 1.
- **Card removal:** after `auth_ok` = 1, set `card_swipe` = 0 → `auth_ok` = 0 next edge. Two failures, remove card, re-swipe, one more failure → `locked` = 1.
- **Timeout** (`TIMEOUT_CYC` = 20): keys 0,1 then 20 idle cycles → `timeout` pulses once; `digits_entered` = 0; no `auth_fail`. A key exactly in the expiry cycle → no pulse.
- **Reset mid-entry:** `reset` after keys 0,1 → all outputs return to their reset values next edge; a subsequent full valid sequence authenticates.
